// File: rtl/lrsc_reservation.sv
// lrsc_reservation
//   Reservation set for the LR.W side of the LR/SC atomic pair. An LR.W
//   records its address and, once memory returns the loaded word, holds
//   both as the active reservation. The reservation is dropped by a
//   snooped write to the same granule, SC completion, a kill (trap,
//   interrupt, xRET, flush) or a timeout. The SC unit compares against
//   reservation_addr_o / reservation_data_o.
//
// Ports
//   clk, reset_n              core clock, synchronous active-low reset
//   stall                     pipeline stall, masks lr_i and sc_done_i
//   lr_i, lr_addr_i           LR.W issue and effective address
//   mem_valid_i, mem_data_i   load data returning for the pending LR
//   sc_done_i                 SC.W completed (pass or fail)
//   snoop_we_i, snoop_addr_i  foreign write seen on the data-memory port
//   kill_i                    trap / interrupt / xRET / flush
//   reservation_valid_o       reservation active
//   reservation_addr_o        reserved address, poisoned when invalid
//   reservation_data_o        word returned by the LR
//   busy_o                    LR issued, data not yet returned

module lrsc_reservation #(
  parameter int GRANULE_LOG2   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        lr_i,
  input  logic [31:0] lr_addr_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  input  logic        sc_done_i,
  input  logic        snoop_we_i,
  input  logic [31:0] snoop_addr_i,
  input  logic        kill_i,
  output logic        reservation_valid_o,
  output logic [31:0] reservation_addr_o,
  output logic [31:0] reservation_data_o,
  output logic        busy_o
);

  // With the timeout disabled the counter is unused, but keep it one bit
  // wide so the declaration stays legal.
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    FILL     = 3'b010,
    RESERVED = 3'b100
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic snoopHit;
  logic timeoutHit;

  // State register; reset drops any reservation or pending fill.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The if/else chain encodes the event priority:
  // kill, LR, SC done, snoop hit, timeout, then memory return. A snoop in
  // the same cycle as an LR is compared against the old addr_q, but the
  // LR wins anyway.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    snoopHit   = snoop_we_i && (state_q != IDLE) &&
                 (snoop_addr_i[31:GRANULE_LOG2] == addr_q[31:GRANULE_LOG2]);
    timeoutHit = (TIMEOUT_CYCLES != 0) && (state_q == RESERVED) &&
                 (cnt_q == CNT_MAX);

    if (kill_i) begin
      state_d = IDLE;
    end else if (lr_i && !stall) begin
      state_d = FILL;
      addr_d  = lr_addr_i;
      cnt_d   = '0;
    end else if (sc_done_i && !stall && (state_q != IDLE)) begin
      state_d = IDLE;
    end else if (snoopHit) begin
      state_d = IDLE;
    end else if (timeoutHit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        FILL: begin
          if (mem_valid_i) begin
            state_d = RESERVED;
            data_d  = mem_data_i;
            cnt_d   = '0;
          end
        end
        RESERVED: begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Outputs depend on registers only. An invalid reservation presents a
  // misaligned address so no aligned SC.W address can ever match it.
  always_comb begin
    reservation_valid_o = (state_q == RESERVED);
    busy_o              = (state_q == FILL);
    reservation_data_o  = data_q;
    reservation_addr_o  = reservation_valid_o ? addr_q : {addr_q[31:2], 2'b01};
  end

endmodule
